// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined MIPS core: opcodes, ALU op classes,
// the decode-to-execute control bundle and the ID/EX update actions.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // An all-zero bundle is a bubble: it never writes registers or memory.
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef enum logic [1:0] {
        ACT_HOLD    = 2'd0,
        ACT_FLUSH   = 2'd1,
        ACT_STALL   = 2'd2,
        ACT_CAPTURE = 2'd3
    } idex_act_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: a load sitting in execute whose destination is
// read by the instruction in decode forces a one-cycle stall.
module hazard_detect (
    input  logic       ex_mem_read,
    input  logic       ex_valid,
    input  logic       flush,
    input  logic [4:0] ex_rt,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    output logic       stall
);

    logic rt_nonzero;
    logic src_match;

    // Both source fields are compared regardless of opcode (conservative);
    // a flush squashes the consumer, so no stall is needed then.
    assign rt_nonzero = (ex_rt != 5'd0);
    assign src_match  = (ex_rt == rs) || (ex_rt == rt);
    assign stall      = ex_mem_read & ex_valid & ~flush & rt_nonzero & src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush, global hold and
// saturating bubble/flush event counters.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          Hold_i,
    input  logic          Flush_i,
    input  logic          RegDst_i,
    input  logic          ALUSrc_i,
    input  logic          RegWrite_i,
    input  logic          MemWrite_i,
    input  logic          MemRead_i,
    input  logic          MemtoReg_i,
    input  logic [1:0]    ALUOp_i,
    input  logic [DW-1:0] PC4_i,
    input  logic [DW-1:0] RD1_i,
    input  logic [DW-1:0] RD2_i,
    input  logic [DW-1:0] Imm_i,
    input  logic [4:0]    RS_i,
    input  logic [4:0]    RT_i,
    input  logic [4:0]    RD_i,
    output logic          Stall_o,
    output logic          EX_RegDst_o,
    output logic          EX_ALUSrc_o,
    output logic          EX_RegWrite_o,
    output logic          EX_MemWrite_o,
    output logic          EX_MemRead_o,
    output logic          EX_MemtoReg_o,
    output logic [1:0]    EX_ALUOp_o,
    output logic [DW-1:0] EX_PC4_o,
    output logic [DW-1:0] EX_RD1_o,
    output logic [DW-1:0] EX_RD2_o,
    output logic [DW-1:0] EX_Imm_o,
    output logic [4:0]    EX_RS_o,
    output logic [4:0]    EX_RT_o,
    output logic [4:0]    EX_RD_o,
    output logic          EX_Valid_o,
    output logic [CW-1:0] BubbleCnt_o,
    output logic [CW-1:0] FlushCnt_o
);

    ctrl_t         dec_ctrl;
    ctrl_t         ex_ctrl;
    idex_act_t     act;
    logic          stall;
    logic [DW-1:0] ex_pc4;
    logic [DW-1:0] ex_rd1;
    logic [DW-1:0] ex_rd2;
    logic [DW-1:0] ex_imm;
    logic [4:0]    ex_rs;
    logic [4:0]    ex_rt;
    logic [4:0]    ex_rd;
    logic          ex_valid;
    logic [CW-1:0] bubble_cnt;
    logic [CW-1:0] flush_cnt;

    assign dec_ctrl.reg_dst    = RegDst_i;
    assign dec_ctrl.alu_src    = ALUSrc_i;
    assign dec_ctrl.reg_write  = RegWrite_i;
    assign dec_ctrl.mem_write  = MemWrite_i;
    assign dec_ctrl.mem_read   = MemRead_i;
    assign dec_ctrl.mem_to_reg = MemtoReg_i;
    assign dec_ctrl.alu_op     = ALUOp_i;

    hazard_detect u_hazard_detect (
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_valid    (ex_valid),
        .flush       (Flush_i),
        .ex_rt       (ex_rt),
        .rs          (RS_i),
        .rt          (RT_i),
        .stall       (stall)
    );

    // Stall is reported even during hold so upstream stays frozen consistently.
    assign Stall_o = stall;

    always_comb begin
        act = ACT_CAPTURE;
        if (Hold_i) begin
            act = ACT_HOLD;
        end else if (Flush_i) begin
            act = ACT_FLUSH;
        end else if (stall) begin
            act = ACT_STALL;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_ctrl    <= '0;
            ex_pc4     <= '0;
            ex_rd1     <= '0;
            ex_rd2     <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_valid   <= 1'b0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            case (act)
                ACT_FLUSH, ACT_STALL: begin
                    ex_ctrl  <= '0;
                    ex_pc4   <= '0;
                    ex_rd1   <= '0;
                    ex_rd2   <= '0;
                    ex_imm   <= '0;
                    ex_rs    <= '0;
                    ex_rt    <= '0;
                    ex_rd    <= '0;
                    ex_valid <= 1'b0;
                    if (act == ACT_FLUSH) begin
                        if (!(&flush_cnt)) flush_cnt <= flush_cnt + CW'(1);
                    end else begin
                        if (!(&bubble_cnt)) bubble_cnt <= bubble_cnt + CW'(1);
                    end
                end
                ACT_CAPTURE: begin
                    ex_ctrl  <= dec_ctrl;
                    ex_pc4   <= PC4_i;
                    ex_rd1   <= RD1_i;
                    ex_rd2   <= RD2_i;
                    ex_imm   <= Imm_i;
                    ex_rs    <= RS_i;
                    ex_rt    <= RT_i;
                    ex_rd    <= RD_i;
                    ex_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign EX_RegDst_o   = ex_ctrl.reg_dst;
    assign EX_ALUSrc_o   = ex_ctrl.alu_src;
    assign EX_RegWrite_o = ex_ctrl.reg_write;
    assign EX_MemWrite_o = ex_ctrl.mem_write;
    assign EX_MemRead_o  = ex_ctrl.mem_read;
    assign EX_MemtoReg_o = ex_ctrl.mem_to_reg;
    assign EX_ALUOp_o    = ex_ctrl.alu_op;
    assign EX_PC4_o      = ex_pc4;
    assign EX_RD1_o      = ex_rd1;
    assign EX_RD2_o      = ex_rd2;
    assign EX_Imm_o      = ex_imm;
    assign EX_RS_o       = ex_rs;
    assign EX_RT_o       = ex_rt;
    assign EX_RD_o       = ex_rd;
    assign EX_Valid_o    = ex_valid;
    assign BubbleCnt_o   = bubble_cnt;
    assign FlushCnt_o    = flush_cnt;

endmodule
